// File: rtl/manchester_host.sv
// Command/response host: transmits a 16-bit command as a Manchester-style frame on TX,
// then decodes the 16-bit reply on RX using the half period measured from its start pulse.
module manchester_host #(
    parameter int HALF     = 72,
    parameter int RESP_TMO = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        send,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] resp,
    output logic        resp_rdy,
    output logic        busy,
    output logic        tmo
);

    localparam int CW = $clog2(RESP_TMO + 4 * HALF + 1);

    localparam logic [CW-1:0] C_HALF_END  = CW'(HALF - 1);
    localparam logic [CW-1:0] C_ONE_RISE  = CW'(HALF / 2 - 1);
    localparam logic [CW-1:0] C_ZERO_RISE = CW'(3 * HALF / 2 - 1);
    localparam logic [CW-1:0] C_BIT_END   = CW'(2 * HALF - 1);
    localparam logic [CW-1:0] C_TMO       = CW'(RESP_TMO - 1);
    localparam logic [CW-1:0] C_WD        = CW'(4 * HALF - 1);

    typedef enum logic [3:0] {
        IDLE,
        T_START_L,
        T_START_H,
        T_BIT_L,
        T_BIT_H,
        R_WAIT,
        R_START_L,
        R_WAIT_FALL,
        R_WAIT_SMP,
        R_WAIT_H
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [CW-1:0] wd, wd_d;
    logic [3:0]    bitcnt, bit_d;
    logic [15:0]   sh, sh_d;
    logic [15:0]   resp_q, resp_d;
    logic [8:0]    per, per_d;
    logic [8:0]    per_cap, cap_d;
    logic          tx_q, tx_d;
    logic          rdy_q, rdy_d;
    logic          tmo_q, tmo_d;
    logic          s1, s2, s3;
    logic          rise, fall;

    assign rise     = s2 & ~s3;
    assign fall     = ~s2 & s3;
    assign TX       = tx_q;
    assign resp     = resp_q;
    assign resp_rdy = rdy_q;
    assign tmo      = tmo_q;
    // Busy stays up through the completion pulse so a same-cycle send is refused.
    assign busy     = (state != IDLE) || rdy_q || tmo_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            wd      <= '0;
            bitcnt  <= '0;
            sh      <= '0;
            resp_q  <= '0;
            per     <= '0;
            per_cap <= '0;
            tx_q    <= 1'b1;
            rdy_q   <= 1'b0;
            tmo_q   <= 1'b0;
            s1      <= 1'b1;
            s2      <= 1'b1;
            s3      <= 1'b1;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            wd      <= wd_d;
            bitcnt  <= bit_d;
            sh      <= sh_d;
            resp_q  <= resp_d;
            per     <= per_d;
            per_cap <= cap_d;
            tx_q    <= tx_d;
            rdy_q   <= rdy_d;
            tmo_q   <= tmo_d;
            s1      <= RX;
            s2      <= s1;
            s3      <= s2;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt + 1'b1;
        bit_d   = bitcnt;
        sh_d    = sh;
        resp_d  = resp_q;
        cap_d   = per_cap;
        tx_d    = tx_q;
        rdy_d   = 1'b0;
        tmo_d   = 1'b0;
        per_d   = (&per) ? per : per + 1'b1;
        wd_d    = (rise || fall) ? '0 : ((&wd) ? wd : wd + 1'b1);

        case (state)
            IDLE: begin
                cnt_d = '0;
                if (send && !busy) begin
                    sh_d    = cmd;
                    tx_d    = 1'b0;
                    state_d = T_START_L;
                end
            end
            T_START_L: begin
                if (cnt == C_HALF_END) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    state_d = T_START_H;
                end
            end
            T_START_H: begin
                if (cnt == C_HALF_END) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    state_d = T_BIT_L;
                end
            end
            T_BIT_L: begin
                if (cnt == (sh[15] ? C_ONE_RISE : C_ZERO_RISE)) begin
                    tx_d    = 1'b1;
                    state_d = T_BIT_H;
                end
            end
            T_BIT_H: begin
                if (cnt == C_BIT_END) begin
                    cnt_d = '0;
                    if (bitcnt == 4'd15) begin
                        bit_d   = '0;
                        state_d = R_WAIT;
                    end else begin
                        bit_d   = bitcnt + 4'd1;
                        sh_d    = {sh[14:0], 1'b0};
                        tx_d    = 1'b0;
                        state_d = T_BIT_L;
                    end
                end
            end
            R_WAIT: begin
                if (fall) begin
                    per_d   = '0;
                    state_d = R_START_L;
                end else if (cnt == C_TMO) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            R_START_L: begin
                if (rise) begin
                    cap_d   = per;
                    state_d = R_WAIT_FALL;
                end
            end
            R_WAIT_FALL: begin
                if (fall) begin
                    per_d   = '0;
                    state_d = R_WAIT_SMP;
                end
            end
            R_WAIT_SMP: begin
                if (per == per_cap) begin
                    sh_d    = {sh[14:0], s2};
                    state_d = R_WAIT_H;
                end
            end
            R_WAIT_H: begin
                if (s2) begin
                    if (bitcnt == 4'd15) begin
                        resp_d  = sh;
                        rdy_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bit_d   = bitcnt + 4'd1;
                        state_d = R_WAIT_FALL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Watchdog wins over a completion in the same cycle, so the two pulses never coincide.
        if ((state inside {R_START_L, R_WAIT_FALL, R_WAIT_SMP, R_WAIT_H})
            && !(rise || fall) && wd == C_WD) begin
            state_d = IDLE;
            resp_d  = resp_q;
            rdy_d   = 1'b0;
            tmo_d   = 1'b1;
        end
    end

endmodule

// File: tb/tb_manchester_host.sv
// Directed bench for manchester_host: decodes TX frames, plays remote replies on RX
// and checks response words, pulses, timeouts and reset behaviour.
module tb_manchester_host;

    localparam int H    = 72;
    localparam int TMO  = 20000;
    localparam int NCAP = 34 * H + 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cmd;
    logic        send;
    logic        RX;
    logic        TX;
    logic [15:0] resp;
    logic        resp_rdy;
    logic        busy;
    logic        tmo;

    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;
    logic tr [0:4095];
    int   cap_busy_low;
    int   cap_cyc0;
    int   last_edge;

    int   n_rdy = 0;
    int   n_tmo = 0;
    int   n_both = 0;
    int   rdy_cyc = 0;
    int   tmo_cyc = 0;
    logic busy_at_pulse = 1'b0;
    logic busy_after = 1'b1;
    logic prev_pulse = 1'b0;

    manchester_host #(.HALF(H), .RESP_TMO(TMO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd      (cmd),
        .send     (send),
        .RX       (RX),
        .TX       (TX),
        .resp     (resp),
        .resp_rdy (resp_rdy),
        .busy     (busy),
        .tmo      (tmo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_pulse <= resp_rdy || tmo;
        if (prev_pulse) busy_after <= busy;
        if (resp_rdy) begin
            n_rdy         <= n_rdy + 1;
            rdy_cyc       <= cyc;
            busy_at_pulse <= busy;
        end
        if (tmo) begin
            n_tmo   <= n_tmo + 1;
            tmo_cyc <= cyc;
        end
        if (resp_rdy && tmo) n_both <= n_both + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int run_len(input int s, input logic v);
        int r = 0;
        while (s + r < NCAP && tr[s + r] == v) r++;
        return r;
    endfunction

    function automatic logic near(input int a, input int b);
        return (a >= b - 1) && (a <= b + 1);
    endfunction

    // Pulses send for one cycle, then records TX and busy for a whole frame; a second
    // send with a different word is issued mid-frame and must be ignored.
    task automatic send_frame(input logic [15:0] c);
        @(negedge clk);
        send = 1'b1;
        cmd  = c;
        cap_busy_low = 0;
        for (int k = 0; k < NCAP; k++) begin
            @(negedge clk);
            if (k == 0) begin
                send     = 1'b0;
                cap_cyc0 = cyc;
            end
            if (k == 100) begin
                send = 1'b1;
                cmd  = 16'hFFFF;
            end
            if (k == 101) send = 1'b0;
            tr[k] = TX;
            if (!busy) cap_busy_low++;
        end
    endtask

    task automatic analyse(output logic [15:0] w, output int terr, output int f15);
        int   i;
        int   r;
        logic b;
        i = 0; terr = 0; w = '0; f15 = 0;
        r = run_len(i, 1'b0); if (!near(r, H)) terr++; i += r;
        r = run_len(i, 1'b1); if (!near(r, H)) terr++; i += r;
        for (int n = 0; n < 16; n++) begin
            if (n == 15) f15 = i;
            r = run_len(i, 1'b0);
            b = (r < H);
            w = {w[14:0], b};
            if (!near(r, b ? H / 2 : 3 * H / 2)) terr++;
            i += r;
            r = run_len(i, 1'b1);
            if (n < 15) begin
                if (!near(r, b ? 3 * H / 2 : H / 2)) terr++;
            end else if (i + r != NCAP) begin
                terr++;
            end
            i += r;
        end
    endtask

    task automatic check_frame(input string tag, input logic [15:0] exp, output int f15);
        logic [15:0] w;
        int terr;
        analyse(w, terr, f15);
        check({tag, "_word"}, w, exp);
        check({tag, "_timing_errs"}, terr, 0);
        check({tag, "_busy_low"}, cap_busy_low, 0);
    endtask

    task automatic drive(input logic v, input int n);
        @(posedge clk);
        #1;
        RX = v;
        last_edge = cyc;
        repeat (n - 1) @(posedge clk);
    endtask

    // Remote unit: start pulse then the first nb bits of w, MSB first, then idle high.
    task automatic reply(input logic [15:0] w, input int h, input int nb);
        int lo;
        drive(1'b0, h);
        drive(1'b1, h);
        for (int n = 0; n < nb; n++) begin
            lo = w[15 - n] ? h / 2 : 3 * h / 2;
            drive(1'b0, lo);
            drive(1'b1, 2 * h - lo);
        end
    endtask

    initial begin
        int f15;
        int r0;
        int t0;
        int d;

        rst_n = 1'b0; send = 1'b0; cmd = '0; RX = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", TX, 1);
        check("rst_busy", busy, 0);
        check("rst_rdy", resp_rdy, 0);
        check("rst_tmo", tmo, 0);
        check("rst_resp", resp, 16'h0000);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        send_frame(16'hA5C3);
        check_frame("a5c3", 16'hA5C3, f15);
        r0 = n_rdy; t0 = n_tmo;
        reply(16'h1234, H, 16);
        repeat (10) @(negedge clk);
        check("resp_1234", resp, 16'h1234);
        check("rdy_cnt_1234", n_rdy - r0, 1);
        check("tmo_cnt_1234", n_tmo - t0, 0);
        check("busy_at_rdy", busy_at_pulse, 1);
        check("busy_after_rdy", busy_after, 0);

        send_frame(16'h0F0F);
        check_frame("0f0f", 16'h0F0F, f15);
        r0 = n_rdy;
        reply(16'hFFFF, 60, 16);
        repeat (10) @(negedge clk);
        check("resp_ffff_h60", resp, 16'hFFFF);
        check("rdy_cnt_ffff", n_rdy - r0, 1);

        send_frame(16'h3C3C);
        check_frame("3c3c", 16'h3C3C, f15);
        r0 = n_rdy; t0 = n_tmo;
        repeat (TMO + 20) @(negedge clk);
        check("noreply_tmo_cnt", n_tmo - t0, 1);
        check("noreply_rdy_cnt", n_rdy - r0, 0);
        check("noreply_tmo_delay", tmo_cyc - (cap_cyc0 + f15), 2 * H + TMO);
        check("noreply_resp", resp, 16'hFFFF);
        check("noreply_busy", busy, 0);

        send_frame(16'h1111);
        check_frame("1111", 16'h1111, f15);
        r0 = n_rdy; t0 = n_tmo;
        reply(16'hB500, H, 7);
        repeat (4 * H + 20) @(negedge clk);
        d = tmo_cyc - last_edge;
        check("abort_tmo_cnt", n_tmo - t0, 1);
        check("abort_rdy_cnt", n_rdy - r0, 0);
        check("abort_tmo_delay_ok", (d >= 4 * H && d <= 4 * H + 4), 1);
        check("abort_resp", resp, 16'hFFFF);

        send_frame(16'h7E81);
        check_frame("7e81", 16'h7E81, f15);
        r0 = n_rdy;
        reply(16'hC33C, H, 16);
        repeat (10) @(negedge clk);
        check("resp_c33c", resp, 16'hC33C);
        check("rdy_cnt_c33c", n_rdy - r0, 1);

        @(negedge clk);
        send = 1'b1; cmd = 16'hA5C3;
        @(negedge clk);
        send = 1'b0;
        repeat (20 * H + 20) @(negedge clk);
        check("bit9_tx_low", TX, 0);
        r0 = n_rdy; t0 = n_tmo;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_tx", TX, 1);
        check("midrst_busy", busy, 0);
        check("midrst_resp", resp, 16'h0000);
        repeat (50) @(negedge clk);
        check("midrst_no_rdy", n_rdy - r0, 0);
        check("midrst_no_tmo", n_tmo - t0, 0);
        check("midrst_tx_idle", TX, 1);

        send_frame(16'h8001);
        check_frame("8001", 16'h8001, f15);
        r0 = n_rdy;
        reply(16'h0000, 60, 16);
        repeat (10) @(negedge clk);
        check("resp_0000_h60", resp, 16'h0000);
        check("rdy_cnt_0000", n_rdy - r0, 1);
        check("pulses_never_together", n_both, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
